// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back data cache controller.
//
// Drives one tag SRAM ({dirty, valid, tag} per line) and one 128-bit line
// data SRAM. Both SRAMs use active-low CEN/WEN/BWEN and have 1-cycle read latency.
// Sits between a 64-bit CPU load/store port and a 128-bit line memory port.
// After reset it clears every tag entry. It then serves hits, writes back dirty
// victims and refills lines.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_*                  CPU request (valid/ready, wr, addr, wdata, wstrb)
//   resp_valid/resp_rdata  one-cycle response pulse, load data
//   tag_*                  tag SRAM (cen, wen, addr, wdata, rdata)
//   dat_*                  data SRAM (cen, wen, bwen, addr, d, q)
//   mem_req_*/mem_resp_*   line memory port (valid/ready request, response pulse)
module dcache_ctrl #(
  parameter int IDX_W = 7,
  parameter int OFF_W = 4,
  parameter int TAG_W = 32 - IDX_W - OFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [31:0]        req_addr,
  input  logic [63:0]        req_wdata,
  input  logic [7:0]         req_wstrb,
  output logic               resp_valid,
  output logic [63:0]        resp_rdata,
  output logic               tag_cen,
  output logic               tag_wen,
  output logic [IDX_W-1:0]   tag_addr,
  output logic [TAG_W+1:0]   tag_wdata,
  input  logic [TAG_W+1:0]   tag_rdata,
  output logic               dat_cen,
  output logic               dat_wen,
  output logic [127:0]       dat_bwen,
  output logic [IDX_W-1:0]   dat_addr,
  output logic [127:0]       dat_d,
  input  logic [127:0]       dat_q,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_req_wr,
  output logic [31:0]        mem_req_addr,
  output logic [127:0]       mem_req_wdata,
  input  logic               mem_resp_valid,
  input  logic [127:0]       mem_resp_rdata
);

  typedef enum logic [3:0] {
    INIT, IDLE, LOOKUP, HIT_WR, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RF_WR, RESP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic               r_half;
  logic               r_wr;
  logic [63:0]        r_wdata;
  logic [7:0]         r_wstrb;
  logic [127:0]       line;

  logic [IDX_W-1:0]   req_idx;
  logic               lk_hit;
  logic               lk_dirty;
  logic [63:0]        lo_mask;
  logic [127:0]       bit_mask;
  logic [127:0]       merged;
  logic [31:0]        line_addr;
  logic               unused_ok;

  // Byte offset bits below the 64-bit half select carry no information here.
  assign unused_ok = ^req_addr[2:0];

  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign line_addr = {r_tag, r_idx, {OFF_W{1'b0}}};

  // Tag entry layout: [TAG_W+1] dirty, [TAG_W] valid, [TAG_W-1:0] tag.
  assign lk_hit   = tag_rdata[TAG_W] && (tag_rdata[TAG_W-1:0] == r_tag);
  assign lk_dirty = tag_rdata[TAG_W+1] && tag_rdata[TAG_W];

  // Per-bit mask of the strobed bytes, placed in the selected 64-bit half.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < 8; i++) lo_mask[i*8 +: 8] = {8{r_wstrb[i]}};
  end
  assign bit_mask = r_half ? {lo_mask, 64'd0} : {64'd0, lo_mask};

  // Refill line with the pending store merged in (a load writes it unchanged).
  assign merged = r_wr ? ((line & ~bit_mask) | ({r_wdata, r_wdata} & bit_mask)) : line;

  // SRAM strobes are decoded from the state. The lookup read must be issued
  // in the acceptance cycle so the data is valid in LOOKUP. Reset forces
  // every strobe inactive even though the state already reads INIT.
  always_comb begin
    tag_cen   = 1'b1;
    tag_wen   = 1'b1;
    tag_addr  = r_idx;
    tag_wdata = '0;
    dat_cen   = 1'b1;
    dat_wen   = 1'b1;
    dat_bwen  = '1;
    dat_addr  = r_idx;
    dat_d     = '0;
    if (!rst) begin
      case (state)
        INIT: begin
          tag_cen  = 1'b0;
          tag_wen  = 1'b0;
          tag_addr = cnt;
        end
        IDLE: if (req_valid) begin
          tag_cen  = 1'b0;
          dat_cen  = 1'b0;
          tag_addr = req_idx;
          dat_addr = req_idx;
        end
        HIT_WR: begin
          dat_cen   = 1'b0;
          dat_wen   = 1'b0;
          dat_bwen  = ~bit_mask;
          dat_d     = {r_wdata, r_wdata};
          tag_cen   = 1'b0;
          tag_wen   = 1'b0;
          tag_wdata = {1'b1, 1'b1, r_tag};
        end
        RF_WR: begin
          dat_cen   = 1'b0;
          dat_wen   = 1'b0;
          dat_bwen  = '0;
          dat_d     = merged;
          tag_cen   = 1'b0;
          tag_wen   = 1'b0;
          tag_wdata = {r_wr, 1'b1, r_tag};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= INIT;
      cnt           <= '0;
      r_tag         <= '0;
      r_idx         <= '0;
      r_half        <= 1'b0;
      r_wr          <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      line          <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == {IDX_W{1'b1}}) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: if (req_valid) begin
          r_tag     <= req_addr[31 -: TAG_W];
          r_idx     <= req_idx;
          r_half    <= req_addr[3];
          r_wr      <= req_wr;
          r_wdata   <= req_wdata;
          r_wstrb   <= req_wstrb;
          req_ready <= 1'b0;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          if (lk_hit) begin
            if (r_wr) begin
              state <= HIT_WR;
            end else begin
              resp_rdata <= r_half ? dat_q[127:64] : dat_q[63:0];
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else if (lk_dirty) begin
            // The request registers double as the victim line latch.
            mem_req_valid <= 1'b1;
            mem_req_wr    <= 1'b1;
            mem_req_addr  <= {tag_rdata[TAG_W-1:0], r_idx, {OFF_W{1'b0}}};
            mem_req_wdata <= dat_q;
            state         <= WB_REQ;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_wr    <= 1'b0;
            mem_req_addr  <= line_addr;
            state         <= RF_REQ;
          end
        end
        HIT_WR: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        WB_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= WB_WAIT;
        end
        // The refill is only requested once the writeback is acknowledged.
        WB_WAIT: if (mem_resp_valid) begin
          mem_req_valid <= 1'b1;
          mem_req_wr    <= 1'b0;
          mem_req_addr  <= line_addr;
          state         <= RF_REQ;
        end
        RF_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= RF_WAIT;
        end
        RF_WAIT: if (mem_resp_valid) begin
          line  <= mem_resp_rdata;
          state <= RF_WR;
        end
        RF_WR: begin
          if (!r_wr) resp_rdata <= r_half ? line[127:64] : line[63:0];
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: randomized self-checking bench for dcache_ctrl.
// The bench models both SRAMs and the line memory. A line-level cache model
// (valid/dirty/tag/data per index plus a backing store) predicts load data,
// writeback/refill traffic and hit latencies.
module tb_dcache_ctrl;
  localparam int IDX_W = 7;
  localparam int OFF_W = 4;
  localparam int TAG_W = 21;
  localparam int LINES = 1 << IDX_W;

  logic               clk, rst;
  logic               req_valid, req_ready, req_wr;
  logic [31:0]        req_addr;
  logic [63:0]        req_wdata;
  logic [7:0]         req_wstrb;
  logic               resp_valid;
  logic [63:0]        resp_rdata;
  logic               tag_cen, tag_wen;
  logic [IDX_W-1:0]   tag_addr;
  logic [TAG_W+1:0]   tag_wdata, tag_rdata;
  logic               dat_cen, dat_wen;
  logic [127:0]       dat_bwen, dat_d, dat_q;
  logic [IDX_W-1:0]   dat_addr;
  logic               mem_req_valid, mem_req_ready, mem_req_wr;
  logic [31:0]        mem_req_addr;
  logic [127:0]       mem_req_wdata;
  logic               mem_resp_valid;
  logic [127:0]       mem_resp_rdata;

  dcache_ctrl #(.IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .tag_cen(tag_cen), .tag_wen(tag_wen), .tag_addr(tag_addr),
    .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .dat_cen(dat_cen), .dat_wen(dat_wen), .dat_bwen(dat_bwen),
    .dat_addr(dat_addr), .dat_d(dat_d), .dat_q(dat_q),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: 1-cycle read latency, active-low strobes and bit mask.
  logic [TAG_W+1:0]       tmem [LINES];
  logic [127:0]           dmem [LINES];
  logic [127:0]           last_bwen;
  logic [IDX_W+TAG_W+1:0] tlog [$];

  always @(posedge clk) begin
    if (!tag_cen) begin
      if (!tag_wen) begin
        tmem[tag_addr] <= tag_wdata;
        tlog.push_back({tag_addr, tag_wdata});
      end else begin
        tag_rdata <= tmem[tag_addr];
      end
    end
    if (!dat_cen) begin
      if (!dat_wen) begin
        dmem[dat_addr] <= (dmem[dat_addr] & dat_bwen) | (dat_d & ~dat_bwen);
        last_bwen      <= dat_bwen;
      end else begin
        dat_q <= dmem[dat_addr];
      end
    end
  end

  // Reference model: cache state per index plus backing memory per line.
  logic               m_valid [LINES];
  logic               m_dirty [LINES];
  logic [TAG_W-1:0]   m_tag   [LINES];
  logic [127:0]       m_data  [LINES];
  logic [127:0]       bmem [logic [31:0]];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Counts req_ready-low cycles from the current (just-released) cycle and
  // checks the tag clear sequence.
  task automatic init_check();
    int low = 0;
    logic saw_resp = 1'b0;
    logic seq_ok = 1'b1;
    logic [IDX_W-1:0] ia;
    while (!req_ready && low < 400) begin
      low++;
      saw_resp |= resp_valid;
      @(negedge clk);
      mem_resp_valid = 1'b0;
    end
    chk("init_ready_low", low, 128);
    chk("init_nwrites", tlog.size(), 128);
    for (int i = 0; i < 128 && i < tlog.size(); i++) begin
      ia = i[IDX_W-1:0];
      if (tlog[i] !== {ia, {(TAG_W+2){1'b0}}}) seq_ok = 1'b0;
    end
    chk("init_seq", seq_ok, 1);
    chk("init_no_resp", saw_resp, 0);
    model_clear();
  endtask

  // Serves one memory transaction: holds ready low dly cycles while checking
  // the request is stable, then acks after a random gap.
  task automatic serve_mem(input logic ewr, input logic [31:0] ea, input logic [127:0] ewd,
                           input int dly, input logic [127:0] rd);
    int n = 0;
    int k;
    logic [162:0] snap;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mreq_valid", mem_req_valid, 1);
    chk("mreq_wr", mem_req_wr, ewr);
    chk("mreq_addr", mem_req_addr, ea);
    if (ewr) chk("mreq_wdata", mem_req_wdata, ewd);
    snap = {mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata};
    repeat (dly) begin
      @(negedge clk);
      chk("mreq_stable", {mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata}, snap);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mreq_drop", mem_req_valid, 0);
    k = $urandom_range(0, 2);
    repeat (k) begin
      @(negedge clk);
      chk("mreq_wait_ack", mem_req_valid, 0);
    end
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rd;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_rdata = {4{$urandom}};
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [63:0] wd,
                        input logic [7:0] ws, input int dly);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    logic             hit, saw;
    logic [127:0]     ln;
    logic [63:0]      exp_rd;
    logic [31:0]      la;
    int n, c0, base;
    idx  = a[10:4];
    tg   = a[31:11];
    base = a[3] ? 64 : 0;
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = wd;
    req_wstrb = ws;
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        la = {m_tag[idx], idx, 4'b0};
        serve_mem(1'b1, la, m_data[idx], dly, '0);
        bmem[la] = m_data[idx];
      end
      la = {tg, idx, 4'b0};
      ln = mem_line(la);
      serve_mem(1'b0, la, '0, dly, ln);
      m_data[idx]  = ln;
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      for (int b = 0; b < 8; b++)
        if (ws[b]) m_data[idx][base + b*8 +: 8] = wd[b*8 +: 8];
      m_dirty[idx] = 1'b1;
    end
    exp_rd = m_data[idx][base +: 64];
    saw = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      saw |= mem_req_valid;
      @(negedge clk);
      n++;
    end
    chk("resp_valid", resp_valid, 1);
    if (hit) begin
      chk("hit_latency", cyc - c0, wr ? 3 : 2);
      chk("hit_no_mem", saw, 0);
    end
    if (!wr) chk("load_data", resp_rdata, exp_rd);
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
    if (!wr) chk("rdata_hold", resp_rdata, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, x, ix, h;
    logic [31:0] a;
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_wr         = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_wstrb      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    model_clear();
    bmem[32'h0000_1000] = 128'h1111_2222_3333_4444_AAAA_BBBB_CCCC_DDDD;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp", {resp_valid, resp_rdata}, 0);
    chk("rst_mreq", {mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata}, 0);
    chk("rst_sram_ctl", {tag_cen, tag_wen, dat_cen, dat_wen}, 4'hF);
    chk("rst_bwen", dat_bwen, {128{1'b1}});
    tlog.delete();
    rst = 1'b0;
    init_check();

    // Clean miss, then the same load hits.
    do_req(1'b0, 32'h0000_1008, '0, '0, 0);
    chk("tag0_after_refill", tmem[0], {2'b01, 21'h2});
    do_req(1'b0, 32'h0000_1008, '0, '0, 0);

    // Store hit on the low half, bytes 0..3.
    do_req(1'b1, 32'h0000_1000, 64'h1122_3344_5566_7788, 8'h0F, 0);
    chk("store_hit_bwen", last_bwen, {{96{1'b1}}, 32'h0});
    chk("tag0_dirty", tmem[0], {2'b11, 21'h2});

    // Conflict miss on a dirty line with a slow memory.
    do_req(1'b0, 32'h0000_1800, '0, '0, 5);

    // Reset while waiting for a refill.
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 32'h0000_2000;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!mem_req_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rstx_mreq_addr", {mem_req_valid, mem_req_addr}, {1'b1, 32'h0000_2000});
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstx_mreq_valid", mem_req_valid, 0);
    chk("rstx_outputs", {req_ready, resp_valid, tag_cen, dat_cen}, 4'b0011);
    repeat (2) @(negedge clk);
    tlog.delete();
    rst = 1'b0;
    mem_resp_valid = 1'b1;          // late response must be ignored
    mem_resp_rdata = {128{1'b1}};
    init_check();

    // Written-back data survives in memory across the reset.
    do_req(1'b0, 32'h0000_1000, '0, '0, 1);

    // Random traffic over a few indexes and conflicting tags.
    for (int i = 0; i < 150; i++) begin
      t  = $urandom_range(8, 11);
      x  = $urandom_range(0, 3);
      ix = x * 37;
      h  = $urandom_range(0, 1);
      a  = {t[TAG_W-1:0], ix[IDX_W-1:0], h[0], 3'b0};
      do_req($urandom_range(0, 1) == 1, a, {$urandom, $urandom},
             8'($urandom), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped write-back cache controller that sequences one tag SRAM and one 128-bit-line data SRAM. The SRAMs use active-low CEN/WEN/BWEN and have 1-cycle read latency. The block sits between the NPC load/store unit (64-bit CPU port) and the memory bus (128-bit line port). It clears all tags after reset, then serves hits, writebacks of dirty victims and refills.

Parameters:
IDX_W, 7, index width; 128 lines
OFF_W, 4, byte offset width; 16-byte lines
TAG_W, 21, tag width (32 - IDX_W - OFF_W); tag entry = {dirty, valid, tag} = TAG_W+2 bits

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  CPU request valid
req_ready  out  1  controller accepts request
req_wr  in  1  1 = store, 0 = load
req_addr  in  32  byte address; req_addr[3] selects 64-bit half
req_wdata  in  64  store data
req_wstrb  in  8  store byte strobes
resp_valid  out  1  one-cycle response pulse (load data or store ack)
resp_rdata  out  64  load data
tag_cen  out  1  tag SRAM enable, active-low
tag_wen  out  1  tag SRAM write, active-low
tag_addr  out  IDX_W  tag index
tag_wdata  out  TAG_W+2  {dirty, valid, tag}
tag_rdata  in  TAG_W+2  tag read data, 1 cycle after read
dat_cen  out  1  data SRAM enable, active-low
dat_wen  out  1  data SRAM write, active-low
dat_bwen  out  128  bit write mask, active-low (0 = write bit)
dat_addr  out  IDX_W  data index
dat_d  out  128  data write line
dat_q  in  128  data read line, 1 cycle after read
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_wr  out  1  1 = line writeback, 0 = line read
mem_req_addr  out  32  line address, low OFF_W bits 0
mem_req_wdata  out  128  writeback line
mem_resp_valid  in  1  read data returned or write acknowledged
mem_resp_rdata  in  128  refill line

Behaviour:
- Reset (async, rst=1):
  - State goes to INIT and the init counter to 0.
  - req_ready=0, resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_req_wr=0, mem_req_addr=0, mem_req_wdata=0.
  - tag_cen=tag_wen=dat_cen=dat_wen=1 and dat_bwen all 1.
  - Reset mid-transaction abandons it; no pending state survives.
- Address split: tag=addr[31:11], idx=addr[10:4], half=addr[3].
- INIT:
  - Writes tag entry 0 to every index 0..127, one per cycle, with counter-driven tag_addr.
  - Leaves INIT after index 127 is written, i.e. after 128 cycles. req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr, wr, wdata and wstrb. Issue tag and data reads at idx in the same cycle. Go to LOOKUP.
- LOOKUP (tag_rdata and dat_q valid):
  - Hit = valid && tag match.
  - Load hit: resp_rdata <= half ? dat_q[127:64] : dat_q[63:0]; go to RESP.
  - Store hit: go to HIT_WR.
  - Miss with victim valid and dirty: latch dat_q and victim tag; go to WB_REQ.
  - Otherwise (miss, clean or invalid victim): go to RF_REQ.
- HIT_WR:
  - Data write at idx. dat_d holds req_wdata replicated to both halves. dat_bwen is cleared only for the bits of strobed bytes in the selected half.
  - Tag write {1, 1, tag}. Go to RESP.
- WB_REQ:
  - mem_req_valid=1, wr=1, addr={victim_tag, idx, 4'b0}, wdata=latched line.
  - Outputs stay stable until mem_req_ready. Then go to WB_WAIT.
- WB_WAIT: wait for mem_resp_valid, then go to RF_REQ.
- RF_REQ: mem_req_valid=1, wr=0, addr={tag, idx, 4'b0}; hold until ready, then go to RF_WAIT.
- RF_WAIT: on mem_resp_valid, latch mem_resp_rdata, then go to RF_WR.
- RF_WR:
  - Full-line data write (bwen=0). For a store, the strobed bytes in the selected half are replaced by req_wdata before writing.
  - Tag write {req_wr, 1, tag}.
  - For a load, resp_rdata <= selected half of the refill line.
  - Go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. resp_rdata holds until the next response.
- Latency from acceptance edge to resp_valid high:
  - load hit: 2 cycles
  - store hit: 3 cycles
  - clean miss: 4 cycles + memory time
- Ordering: a dirty victim writeback always fully completes (ack received) before the refill request is issued.
- mem_resp_valid outside WB_WAIT/RF_WAIT is ignored. Only one memory transaction is outstanding at a time.
- SRAM signals not named in a state are inactive (CEN=1, WEN=1, BWEN all 1).
- Writes to the same index back-to-back are safe: a request is accepted only in IDLE, after the previous write has completed.

Test Plan:
- Reset, hold rst 3 cycles, release → req_ready=0 for exactly 128 cycles; 128 tag writes of 0 to indexes 0..127 in order; req_ready=1 after.
- Load 0x0000_1008 after init → miss; mem read addr 0x0000_1000. Return line 0x...AAAA_BBBB_CCCC_DDDD → resp_rdata = upper 64 bits; tag[0x00] = {0,1,0x2}.
- Repeat same load → resp_valid exactly 2 cycles after acceptance; no mem_req_valid.
- Store 0x0000_1000, wstrb=0x0F, wdata=0x1122334455667788 (hit) → dat_bwen[31:0]=0, all other bits 1; tag entry dirty=1; resp_valid 3 cycles after acceptance.
- Load 0x0000_1800 (same idx, new tag) → first a writeback to 0x0000_1000 carrying the merged line; refill read of 0x0000_1800 only after the write ack; hold mem_req_ready=0 for 5 cycles and check mem_req_* stay stable.
- Assert rst during RF_WAIT → mem_req_valid=0 immediately; INIT restarts; a late mem_resp_valid is ignored; no resp_valid.
